dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu_pkg.sv | 37 +++
 rtl/dmem_lsu_array.sv | 24 ++
 rtl/dmem_lsu.sv | 128 ++++++++++++
 tb/tb_dmem_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared core definitions for the data-memory load/store unit: funct3 memory
// types, FSM state codes, latched request record and load-extension helper.
package dmem_lsu_pkg;

  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        write;
    logic [2:0]  mtype;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } lsu_req_t;

  // Shift the addressed lane down to bit 0, then sign/zero extend by type.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  mtype,
                                              input logic [1:0]  lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (mtype)
      MT_B:    return {{24{sh[7]}}, sh[7:0]};
      MT_BU:   return {24'h0, sh[7:0]};
      MT_H:    return {{16{sh[15]}}, sh[15:0]};
      MT_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_array.sv
// Byte-enabled word storage: synchronous per-lane write, asynchronous read.
// Contents are deliberately never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 16384,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[widx];

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a little-endian byte-enabled data memory:
// request/response handshakes, fault screening and LATENCY-cycle access timer.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUSY  | legal access in flight, down-counter running to 0
// RESP  | resp_valid high, outputs held until resp_ready
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]    state;
  logic [3:0]    cnt;
  lsu_req_t      req_q;
  logic [AW-1:0] widx_q;
  logic          accept;
  logic          fault;
  logic          busy_done;
  logic [3:0]    we;
  logic [31:0]   wdata_lanes;
  logic [31:0]   arr_rdata;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;
  assign busy_done  = (state == ST_BUSY) && (cnt == 4'd0);

  always_comb begin
    fault = 1'b0;
    if (!(req_type inside {MT_B, MT_H, MT_W, MT_BU, MT_HU})) fault = 1'b1;
    if ((req_type == MT_H || req_type == MT_HU) && req_addr[0]) fault = 1'b1;
    if (req_type == MT_W && req_addr[1:0] != 2'b00) fault = 1'b1;
    if (req_addr[31:2] >= 30'(DEPTH_WORDS)) fault = 1'b1;
    if (req_write && (req_type == MT_BU || req_type == MT_HU)) fault = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    we          = 4'b0000;
    wdata_lanes = req_q.wdata;
    case (req_q.mtype)
      MT_B: begin
        wdata_lanes = {4{req_q.wdata[7:0]}};
        we          = 4'b0001 << req_q.lane;
      end
      MT_H: begin
        wdata_lanes = {2{req_q.wdata[15:0]}};
        we          = req_q.lane[1] ? 4'b1100 : 4'b0011;
      end
      MT_W:    we = 4'b1111;
      default: we = 4'b0000;
    endcase
    if (!(busy_done && req_q.write)) we = 4'b0000;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dmem_array (
    .clk  (clk),
    .we   (we),
    .widx (widx_q),
    .wdata(wdata_lanes),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      widx_q     <= '0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q  <= '{write: req_write, mtype: req_type,
                        lane: req_addr[1:0], wdata: req_wdata};
            widx_q <= req_addr[AW+1:2];
            if (fault) begin
              state      <= ST_RESP;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state <= ST_BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            state      <= ST_RESP;
            resp_err   <= 1'b0;
            resp_rdata <= req_q.write ? 32'h0
                                      : load_extend(arr_rdata, req_q.mtype, req_q.lane);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a default instance checked against a byte-level memory
// model plus a LATENCY=3 / DEPTH_WORDS=16 instance for timing and range cases.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_write = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic        rr0 = 1'b0, rr1 = 1'b0;
  logic        rdy0, rdy1, vld0, vld1, er0, er1;
  logic [31:0] rd0, rd1;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0] mem0 [logic [31:0]];

  always #5 clk = ~clk;

  dmem_lsu u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld0), .resp_ready(rr0), .resp_rdata(rd0), .resp_err(er0)
  );

  dmem_lsu #(.DEPTH_WORDS(16), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld1), .resp_ready(rr1), .resp_rdata(rd1), .resp_err(er1)
  );

  function automatic logic o_ready(input int d);  return (d == 0) ? rdy0 : rdy1; endfunction
  function automatic logic o_valid(input int d);  return (d == 0) ? vld0 : vld1; endfunction
  function automatic logic o_err(input int d);    return (d == 0) ? er0  : er1;  endfunction
  function automatic logic [31:0] o_rdata(input int d); return (d == 0) ? rd0 : rd1; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for undefined types.
  function automatic int msize(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit mfault(input logic w, input logic [2:0] t,
                                input logic [31:0] a, input longint depth);
    int s;
    s = msize(t);
    if (s == 0) return 1'b1;
    if ((a % s) != 0) return 1'b1;
    if (longint'(a / 4) >= depth) return 1'b1;
    if (w && (t == 3'b100 || t == 3'b101)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] t, input logic [31:0] a);
    logic [31:0] v;
    int s;
    v = 32'h0;
    s = msize(t);
    for (int i = 0; i < s; i++) v = v + (32'(mem0[a + i]) << (8 * i));
    if (t == 3'b000 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
    if (t == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic mstore(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] v;
    v = wd;
    for (int i = 0; i < msize(t); i++) begin
      mem0[a + i] = v[7:0];
      v = v >> 8;
    end
  endtask

  // One full transaction; exp_lat counts clock edges after the accept edge.
  task automatic access(input string tag, input int d, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] r0;
    logic        e0;
    int          lat;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(o_ready(d)), 32'd1);
    req_write = w; req_type = t; req_addr = a; req_wdata = wd;
    if (d == 0) rv0 = 1'b1; else rv1 = 1'b1;
    @(posedge clk); #1;
    rv0 = 1'b0; rv1 = 1'b0;
    req_write = 1'($urandom); req_type = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!o_valid(d) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_resp_valid"}, 32'(o_valid(d)), 32'd1);
    if (!o_valid(d)) return;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(o_err(d)), 32'(exp_err));
    check({tag, "_rdata"}, o_rdata(d), exp_rd);
    r0 = o_rdata(d);
    e0 = o_err(d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(o_valid(d)), 32'd1);
      check({tag, "_hold_rdata"}, o_rdata(d), r0);
      check({tag, "_hold_err"}, 32'(o_err(d)), 32'(e0));
    end
    @(negedge clk);
    if (d == 0) rr0 = 1'b1; else rr1 = 1'b1;
    check({tag, "_bubble"}, 32'(o_ready(d)), 32'd0);
    @(posedge clk); #1;
    rr0 = 1'b0; rr1 = 1'b0;
    check({tag, "_released"}, 32'(o_valid(d)), 32'd0);
  endtask

  // Transaction on the default instance with expectations from the model.
  task automatic run_op(input string tag, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic        e;
    logic [31:0] r;
    e = mfault(w, t, a, 16384);
    r = (e || w) ? 32'h0 : mload(t, a);
    access(tag, 0, w, t, a, wd, hold, r, e, e ? 0 : 1);
    if (!e && w) mstore(t, a, wd);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(rdy0), 32'd1);
    check("rst_resp_valid", 32'(vld0), 32'd0);
    check("rst_resp_rdata", rd0, 32'h0);
    check("rst_resp_err", 32'(er0), 32'd0);
    check("rst_resp_valid1", 32'(vld1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Endianness, extension and sub-word store merging against fixed values.
    access("sw_100", 0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1);
    mstore(3'b010, 32'h100, 32'hDEADBEEF);
    access("lb_103", 0, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'hFFFFFFDE, 1'b0, 1);
    access("lbu_103", 0, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h000000DE, 1'b0, 1);
    access("lh_102", 0, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'hFFFFDEAD, 1'b0, 1);
    access("lhu_100", 0, 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h0000BEEF, 1'b0, 1);
    run_op("sw_40", 1'b1, 3'b010, 32'h40, 32'h11223344, 0);
    run_op("sb_41", 1'b1, 3'b000, 32'h41, 32'hFFFFFFAA, 0);
    access("lw_40", 0, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h1122AA44, 1'b0, 1);
    run_op("sh_42", 1'b1, 3'b001, 32'h42, 32'h0000BEEF, 0);
    access("lw_40b", 0, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'hBEEFAA44, 1'b0, 1);

    // Faults: response on the accept edge, no side effect.
    access("lw_102", 0, 1'b0, 3'b010, 32'h102, 32'h0, 2, 32'h0, 1'b1, 0);
    access("lh_103", 0, 1'b0, 3'b001, 32'h103, 32'h0, 0, 32'h0, 1'b1, 0);
    access("sw_102", 0, 1'b1, 3'b010, 32'h102, 32'h12345678, 0, 32'h0, 1'b1, 0);
    access("shu_100", 0, 1'b1, 3'b101, 32'h100, 32'h00001234, 0, 32'h0, 1'b1, 0);
    access("type_011", 0, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1, 0);
    access("lw_100_kept", 0, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1);
    access("lw_range", 0, 1'b0, 3'b010, 32'h10000, 32'h0, 0, 32'h0, 1'b1, 0);
    run_op("sw_last", 1'b1, 3'b010, 32'hFFFC, 32'h0BADF00D, 0);
    run_op("lw_last", 1'b0, 3'b010, 32'hFFFC, 32'h0, 0);

    // Reset in BUSY aborts the store and its response.
    run_op("sw_20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0);
    @(negedge clk);
    req_write = 1'b1; req_type = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
    rv0 = 1'b1;
    @(posedge clk); #1;
    rv0 = 1'b0;
    rst = 1'b1;
    #2;
    check("abort_resp_valid", 32'(vld0), 32'd0);
    check("abort_req_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_resp", 32'(vld0), 32'd0);
    end
    access("lw_20_prior", 0, 1'b0, 3'b010, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1);

    // Randomized traffic over a pre-filled window, including misaligned and out-of-range.
    for (int i = 0; i < 16; i++)
      run_op("fill", 1'b1, 3'b010, 32'h200 + 32'(4 * i), $urandom, 0);
    for (int i = 0; i < 60; i++) begin
      t = 3'($urandom_range(0, 7));
      a = 32'h200 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = 32'h10000 + 32'($urandom_range(0, 255));
      run_op("rand", 1'($urandom_range(0, 1)), t, a, $urandom, $urandom_range(0, 2));
    end

    // LATENCY=3, DEPTH_WORDS=16 instance.
    access("l3_sw_10", 1, 1'b1, 3'b010, 32'h10, 32'h13579BDF, 0, 32'h0, 1'b0, 3);
    access("l3_lw_10", 1, 1'b0, 3'b010, 32'h10, 32'h0, 5, 32'h13579BDF, 1'b0, 3);
    access("l3_lw_40", 1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h0, 1'b1, 0);
    access("l3_sw_3c", 1, 1'b1, 3'b010, 32'h3C, 32'h80010000, 0, 32'h0, 1'b0, 3);
    access("l3_lh_3e", 1, 1'b0, 3'b001, 32'h3E, 32'h0, 1, 32'hFFFF8001, 1'b0, 3);
    access("l3_lbu_3f", 1, 1'b0, 3'b100, 32'h3F, 32'h0, 0, 32'h00000080, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
